vx_run_sequencer: RTL
=====================

// Module: vx_run_sequencer
// PURPOSE
//  Synthesizable run controller for the simulation/synthesis harness around VX_vortex_to_local_mem.
//  On start it holds the DUT in reset for a set number of cycles, then releases it and counts run cycles.
//  It tracks per-core ebreak, stops on all-cores or any-core completion, and waits for busy to drain.
//  It enforces a programmable timeout and holds the result flags and counters until the next start.
// PARAMETERS
//  NUM_CORES     4    number of monitored core channels (>=1)
//  RESET_CYCLES  8    cycles dut_reset is held high after start (>=1)
//  CYCLE_W       32   width of run cycle counter
//  DRAIN_MAX     256  max cycles to wait for core_busy==0 after stop condition (>=1)
//  STOP_ANY      0    0: stop when every core has ebreak; 1: stop on first ebreak
// PORTS
//  clk            in   1            clock
//  reset          in   1            asynchronous, active-low reset
//  start          in   1            single-cycle pulse; sampled in IDLE or DONE, ignored otherwise
//  timeout_limit  in   CYCLE_W      run-cycle limit, latched on start; 0 = no timeout
//  core_busy      in   NUM_CORES    per-core busy from DUT
//  core_ebreak    in   NUM_CORES    per-core ebreak pulse/level from DUT
//  dut_reset      out  1            active-high reset to DUT
//  running        out  1            high in RUN or DRAIN
//  done           out  1            high in DONE
//  timed_out      out  1            sticky; run ended by timeout
//  drain_err      out  1            sticky; busy failed to clear within DRAIN_MAX
//  done_mask      out  NUM_CORES    sticky per-core ebreak seen during RUN
//  cycle_count    out  CYCLE_W      RUN cycles elapsed; saturates at all-ones
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, dut_reset=1, running=0, done=0, timed_out=0, drain_err=0,
//   done_mask=0, cycle_count=0, internal counters=0, latched limit=0.
//  States: IDLE, RST, RUN, DRAIN, DONE. dut_reset=1 in IDLE and RST, 0 in RUN, DRAIN, DONE.
//  IDLE/DONE + start: clear flags, done_mask, and cycle_count; latch timeout_limit; enter RST with rst_cnt=0.
//  RST: rst_cnt increments; when rst_cnt==RESET_CYCLES-1, enter RUN. dut_reset is high for exactly RESET_CYCLES cycles.
//  RUN: each cycle, cycle_count++ (saturating) and done_mask |= core_ebreak.
//   Stop condition: STOP_ANY ? |(done_mask|core_ebreak) : &(done_mask|core_ebreak). The current-cycle ebreak counts.
//   Stop condition true -> DRAIN with drain_cnt=0.
//   Else if limit!=0 and cycle_count+1 >= limit -> timed_out=1, DONE.
//   If stop and timeout occur in the same cycle, stop wins and timed_out stays 0.
//  DRAIN: cycle_count frozen; done_mask keeps accumulating.
//   core_busy==0 -> DONE.
//   Else if drain_cnt==DRAIN_MAX-1 -> drain_err=1, DONE. Else drain_cnt++.
//  DONE: all outputs hold; only start leaves this state.
//  start in RST/RUN/DRAIN: ignored, with no effect.
//  Mid-run reset: immediate async return to IDLE with reset values; DUT is re-held in reset.
//  Output latency: registered outputs; a state change is visible one cycle after the causing input edge.
// STRUCTURE
//  Shared package vx_run_pkg: state enum typedef (run_state_t, 3 bits) and a STOP_ALL/STOP_ANY constant pair.
//  One sub-module is natural: vx_sat_counter (parametrised width, clear, enable, saturating).
//   Instantiate it for cycle_count; rst_cnt and drain_cnt are plain counters in the top level.
//  Single always_ff for the FSM and flags, plus an always_comb for the next state. No other hierarchy.
// TESTING
//  1 RESET_CYCLES=8, start at t0 -> dut_reset high for exactly 8 cycles, then running=1, cycle_count counts from 1.
//  2 NUM_CORES=4, STOP_ANY=0; ebreak cores 0,2 at cycle 10 and cores 1,3 at cycle 20; busy drops 3 cycles later
//    -> done_mask=4'hF, cycle_count=20, done=1, timed_out=0, drain_err=0.
//  3 timeout_limit=50, no ebreak -> done at run cycle 50, timed_out=1, cycle_count=50, done_mask=0.
//  4 timeout_limit=50, all ebreak on cycle 50 -> stop wins: DRAIN then DONE, timed_out=0.
//  5 STOP_ANY=1, core1 ebreak, busy stuck high, DRAIN_MAX=256 -> drain_err=1 after 256 DRAIN cycles, done_mask=4'b0010.
//  6 reset=0 mid-RUN, then start while in RST -> all outputs return to reset values, dut_reset=1;
//    start in RST is ignored and the RST length is unchanged.

Source files
------------

// File: rtl/vx_run_pkg.sv
// Shared types and constants for the VX run sequencer.
// Holds the controller state encoding and the stop-mode selector values.
package vx_run_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } run_state_t;

  localparam bit STOP_ALL = 1'b0;
  localparam bit STOP_ANY = 1'b1;

endpackage

// File: rtl/vx_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module vx_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/vx_run_sequencer.sv
// Run controller for the VX_vortex_to_local_mem harness: holds the DUT in reset,
// runs it, detects ebreak completion or timeout, drains busy and holds the results.
module vx_run_sequencer #(
  parameter int NUM_CORES    = 4,
  parameter int RESET_CYCLES = 8,
  parameter int CYCLE_W      = 32,
  parameter int DRAIN_MAX    = 256,
  parameter bit STOP_ANY     = vx_run_pkg::STOP_ALL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CYCLE_W-1:0]   timeout_limit,
  input  logic [NUM_CORES-1:0] core_busy,
  input  logic [NUM_CORES-1:0] core_ebreak,
  output logic                 dut_reset,
  output logic                 running,
  output logic                 done,
  output logic                 timed_out,
  output logic                 drain_err,
  output logic [NUM_CORES-1:0] done_mask,
  output logic [CYCLE_W-1:0]   cycle_count
);

  import vx_run_pkg::*;

  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

  run_state_t           state, state_nx;
  logic [RW-1:0]        rst_cnt;
  logic [DW-1:0]        drain_cnt;
  logic [CYCLE_W-1:0]   limit;
  logic [NUM_CORES-1:0] seen;
  logic                 start_ok, stop_hit, limit_hit;

  // The ebreak arriving this cycle already counts toward the stop decision.
  assign seen      = done_mask | core_ebreak;
  assign stop_hit  = (STOP_ANY == vx_run_pkg::STOP_ANY) ? |seen : &seen;
  assign limit_hit = (limit != '0) &&
                     (({1'b0, cycle_count} + (CYCLE_W+1)'(1)) >= {1'b0, limit});
  assign start_ok  = start && ((state == IDLE) || (state == DONE));

  assign dut_reset = (state == IDLE) || (state == RST);
  assign running   = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

  vx_sat_counter #(.W(CYCLE_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (state == RUN),
    .count (cycle_count)
  );

  // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start_ok) state_nx = RST;
      RST:        if (rst_cnt == RST_LAST) state_nx = RUN;
      RUN: begin
        if (stop_hit)       state_nx = DRAIN;
        else if (limit_hit) state_nx = DONE;
      end
      DRAIN: begin
        if (core_busy == '0)              state_nx = DONE;
        else if (drain_cnt == DRAIN_LAST) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rst_cnt   <= '0;
      drain_cnt <= '0;
      limit     <= '0;
      timed_out <= 1'b0;
      drain_err <= 1'b0;
      done_mask <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            rst_cnt   <= '0;
            limit     <= timeout_limit;
            timed_out <= 1'b0;
            drain_err <= 1'b0;
            done_mask <= '0;
          end
        end
        RST: if (rst_cnt != RST_LAST) rst_cnt <= rst_cnt + RW'(1);
        RUN: begin
          done_mask <= seen;
          if (stop_hit)       drain_cnt <= '0;
          else if (limit_hit) timed_out <= 1'b1;
        end
        DRAIN: begin
          done_mask <= seen;
          if (core_busy != '0) begin
            if (drain_cnt == DRAIN_LAST) drain_err <= 1'b1;
            else                         drain_cnt <= drain_cnt + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
